// File: rtl/interval_timer_core_if.sv
// OCP-style slave bus for the interval timer: command/address/data from the
// master, accept plus registered response/data from the slave.
interface interval_timer_core_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BEN_WIDTH  = 4
);
    logic [ADDR_WIDTH-1:0] i_MAddr;
    logic [2:0]            i_MCmd;
    logic [DATA_WIDTH-1:0] i_MData;
    logic [BEN_WIDTH-1:0]  i_MByteEn;
    logic                  o_SCmdAccept;
    logic [31:0]           o_SData;
    logic [1:0]            o_SResp;

    modport master (
        output i_MAddr, i_MCmd, i_MData, i_MByteEn,
        input  o_SCmdAccept, o_SData, o_SResp
    );

    modport slave (
        input  i_MAddr, i_MCmd, i_MData, i_MByteEn,
        output o_SCmdAccept, o_SData, o_SResp
    );
endinterface

// File: rtl/interval_timer_core.sv
// Programmable interval timer: CTRL/CNTR/CURR registers behind a zero-wait
// OCP slave, 32-bit down-counter with optional auto-reload and interrupt.
module interval_timer_core (
    input  logic                  clk,
    input  logic                  nrst,
    interval_timer_core_if.slave  bus,
    output logic                  o_intr
);
    localparam logic [2:0] CMD_WRITE = 3'd1;
    localparam logic [2:0] CMD_READ  = 3'd2;
    localparam logic [1:0] RESP_NULL = 2'd0;
    localparam logic [1:0] RESP_DVA  = 2'd1;
    localparam logic [1:0] A_CTRL    = 2'd0;
    localparam logic [1:0] A_CNTR    = 2'd1;
    localparam logic [1:0] A_CURR    = 2'd2;

    // ctrl bit order: [2] imask, [1] reload, [0] enable
    logic [2:0]  ctrl_q, ctrl_d;
    logic [31:0] cntr_q, cntr_d;
    logic [31:0] curr_q, curr_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  resp_q, resp_d;
    logic        intr_q, intr_d;

    logic        cmd_wr, cmd_rd, ctrl_wr;
    logic [1:0]  sel;
    logic [31:0] wr_mask;
    logic [2:0]  ctrl_new;
    logic        unused_addr;

    assign unused_addr = ^{bus.i_MAddr[31:4], bus.i_MAddr[1:0]};

    always_comb begin
        cmd_wr = (bus.i_MCmd == CMD_WRITE);
        cmd_rd = (bus.i_MCmd == CMD_READ);
        sel    = bus.i_MAddr[3:2];
        for (int b = 0; b < 4; b++) begin
            wr_mask[8*b +: 8] = {8{bus.i_MByteEn[b]}};
        end
        ctrl_new = (ctrl_q & ~wr_mask[2:0]) | (bus.i_MData[2:0] & wr_mask[2:0]);
        // CTRL lives entirely in byte lane 0; a write with that lane off is a no-op
        ctrl_wr  = cmd_wr && (sel == A_CTRL) && bus.i_MByteEn[0];
    end

    always_comb begin
        ctrl_d = ctrl_q;
        cntr_d = cntr_q;
        curr_d = curr_q;
        intr_d = 1'b0;

        if (cmd_wr && (sel == A_CNTR)) begin
            cntr_d = (cntr_q & ~wr_mask) | (bus.i_MData & wr_mask);
        end

        // A CTRL write overrides any decrement or expiry in the same cycle
        if (ctrl_wr) begin
            ctrl_d = ctrl_new;
            if (ctrl_new[0]) begin
                curr_d = cntr_d;
            end
        end else if (ctrl_q[0]) begin
            if (curr_q > 32'd1) begin
                curr_d = curr_q - 32'd1;
            end else if (curr_q == 32'd1) begin
                intr_d = ctrl_q[2];
                if (ctrl_q[1]) begin
                    curr_d = cntr_q;
                end else begin
                    curr_d    = 32'd0;
                    ctrl_d[0] = 1'b0;
                end
            end
        end

        resp_d  = (cmd_wr || cmd_rd) ? RESP_DVA : RESP_NULL;
        rdata_d = 32'd0;
        if (cmd_rd) begin
            case (sel)
                A_CTRL:  rdata_d = {29'd0, ctrl_q};
                A_CNTR:  rdata_d = cntr_q;
                A_CURR:  rdata_d = curr_q;
                default: rdata_d = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            ctrl_q  <= 3'd0;
            cntr_q  <= 32'd0;
            curr_q  <= 32'd0;
            rdata_q <= 32'd0;
            resp_q  <= RESP_NULL;
            intr_q  <= 1'b0;
        end else begin
            ctrl_q  <= ctrl_d;
            cntr_q  <= cntr_d;
            curr_q  <= curr_d;
            rdata_q <= rdata_d;
            resp_q  <= resp_d;
            intr_q  <= intr_d;
        end
    end

    assign bus.o_SCmdAccept = cmd_wr || cmd_rd;
    assign bus.o_SData      = rdata_q;
    assign bus.o_SResp      = resp_q;
    assign o_intr           = intr_q;
endmodule

// File: tb/tb_interval_timer_core.sv
// Directed bench for interval_timer_core: register access, auto-reload,
// CNTR update while running, one-shot, stop/stall, collision and reset.
module tb_interval_timer_core;
    localparam logic [31:0] A_CTRL = 32'h0;
    localparam logic [31:0] A_CNTR = 32'h4;
    localparam logic [31:0] A_CURR = 32'h8;
    localparam logic [31:0] A_RSVD = 32'hC;

    logic clk;
    logic nrst;
    logic intr;
    int   total  = 0;
    int   passed = 0;
    int   fails  = 0;

    interval_timer_core_if bus ();

    interval_timer_core dut (
        .clk    (clk),
        .nrst   (nrst),
        .bus    (bus.slave),
        .o_intr (intr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One bus cycle: drive at negedge, check accept, then check the
    // response cycle (one edge later) for resp, data and interrupt.
    task automatic do_op(input logic [2:0] cmd, input logic [31:0] addr,
                         input logic [31:0] data, input logic [3:0] be,
                         input logic [31:0] exp_data, input logic exp_intr,
                         input string tag);
        logic active;
        active = (cmd == 3'd1) || (cmd == 3'd2);
        @(negedge clk);
        bus.i_MCmd    = cmd;
        bus.i_MAddr   = addr;
        bus.i_MData   = data;
        bus.i_MByteEn = be;
        #1;
        chk({tag, " accept"}, {31'd0, bus.o_SCmdAccept}, {31'd0, active});
        @(posedge clk);
        #1;
        bus.i_MCmd    = 3'd0;
        bus.i_MByteEn = 4'h0;
        chk({tag, " resp"}, {30'd0, bus.o_SResp}, active ? 32'd1 : 32'd0);
        chk({tag, " data"}, bus.o_SData, exp_data);
        chk({tag, " intr"}, {31'd0, intr}, {31'd0, exp_intr});
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] be, input logic exp_intr, input string tag);
        do_op(3'd1, addr, data, be, 32'd0, exp_intr, tag);
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] exp,
                      input logic exp_intr, input string tag);
        do_op(3'd2, addr, 32'd0, 4'h0, exp, exp_intr, tag);
    endtask

    initial begin
        logic [31:0] e;
        nrst          = 1'b0;
        bus.i_MCmd    = 3'd0;
        bus.i_MAddr   = 32'd0;
        bus.i_MData   = 32'd0;
        bus.i_MByteEn = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst intr", {31'd0, intr}, 32'd0);
        chk("rst resp", {30'd0, bus.o_SResp}, 32'd0);
        chk("rst data", bus.o_SData, 32'd0);
        nrst = 1'b1;

        // register access
        wr(A_CNTR, 32'h10, 4'hF, 1'b0, "wr cntr");
        rd(A_CNTR, 32'h10, 1'b0, "rd cntr");
        rd(A_CTRL, 32'h0, 1'b0, "rd ctrl");
        rd(A_CURR, 32'h0, 1'b0, "rd curr");
        rd(A_RSVD, 32'h0, 1'b0, "rd rsvd");
        wr(A_RSVD, 32'hFFFF_FFFF, 4'hF, 1'b0, "wr rsvd");
        rd(A_RSVD, 32'h0, 1'b0, "rd rsvd2");
        wr(A_CURR, 32'h55, 4'hF, 1'b0, "wr curr");
        rd(A_CURR, 32'h0, 1'b0, "rd curr ro");
        wr(A_CNTR, 32'hAABB_CCDD, 4'hF, 1'b0, "wr cntr full");
        wr(A_CNTR, 32'h1122_3344, 4'h5, 1'b0, "wr cntr be5");
        rd(A_CNTR, 32'hAA22_CC44, 1'b0, "rd cntr be");
        do_op(3'd3, A_CNTR, 32'h0, 4'hF, 32'd0, 1'b0, "cmd3 idle");
        do_op(3'd0, A_CNTR, 32'h0, 4'hF, 32'd0, 1'b0, "cmd0 idle");
        rd(A_CNTR, 32'hAA22_CC44, 1'b0, "rd cntr after idle");

        // auto-reload, period 16
        wr(A_CNTR, 32'h10, 4'hF, 1'b0, "wr cntr16");
        wr(A_CTRL, 32'h7, 4'hF, 1'b0, "wr ctrl7");
        for (int i = 0; i < 32; i++) begin
            e = 32'd16 - (i % 16);
            rd(A_CURR, e, e == 32'd1, $sformatf("ar curr%0d", i));
        end

        // CNTR change while running: current period completes, then period 4
        wr(A_CNTR, 32'h4, 4'hF, 1'b0, "wr cntr4 run");
        for (int i = 0; i < 15; i++) begin
            e = 32'd15 - i;
            rd(A_CURR, e, e == 32'd1, $sformatf("tail curr%0d", i));
        end
        for (int i = 0; i < 8; i++) begin
            e = 32'd4 - (i % 4);
            rd(A_CURR, e, e == 32'd1, $sformatf("p4 curr%0d", i));
        end
        rd(A_CTRL, 32'h7, 1'b0, "rd ctrl7");

        // stop freezes CURR
        wr(A_CTRL, 32'h0, 4'hF, 1'b0, "stop");
        rd(A_CURR, 32'h3, 1'b0, "frozen a");
        rd(A_CURR, 32'h3, 1'b0, "frozen b");

        // CTRL write in an expiry cycle suppresses the interrupt
        wr(A_CTRL, 32'h7, 4'hF, 1'b0, "restart");
        rd(A_CURR, 32'h4, 1'b0, "col curr4");
        rd(A_CURR, 32'h3, 1'b0, "col curr3");
        rd(A_CURR, 32'h2, 1'b0, "col curr2");
        wr(A_CTRL, 32'h7, 4'hF, 1'b0, "col wr at expiry");
        rd(A_CURR, 32'h4, 1'b0, "col reloaded");
        wr(A_CTRL, 32'h0, 4'hF, 1'b0, "stop2");

        // one-shot, masked
        wr(A_CNTR, 32'h4, 4'hF, 1'b0, "os cntr");
        wr(A_CTRL, 32'h1, 4'hF, 1'b0, "os ctrl1");
        rd(A_CURR, 32'h4, 1'b0, "os 4");
        rd(A_CURR, 32'h3, 1'b0, "os 3");
        rd(A_CURR, 32'h2, 1'b0, "os 2");
        rd(A_CURR, 32'h1, 1'b0, "os 1");
        rd(A_CURR, 32'h0, 1'b0, "os 0a");
        rd(A_CURR, 32'h0, 1'b0, "os 0b");
        rd(A_CTRL, 32'h0, 1'b0, "os ctrl");

        // one-shot with interrupt enabled
        wr(A_CNTR, 32'h2, 4'hF, 1'b0, "osi cntr");
        wr(A_CTRL, 32'h5, 4'hF, 1'b0, "osi ctrl5");
        rd(A_CURR, 32'h2, 1'b0, "osi 2");
        rd(A_CURR, 32'h1, 1'b1, "osi 1");
        rd(A_CURR, 32'h0, 1'b0, "osi 0");
        rd(A_CTRL, 32'h4, 1'b0, "osi ctrl");

        // stall with CNTR=0
        wr(A_CNTR, 32'h0, 4'hF, 1'b0, "stall cntr0");
        wr(A_CTRL, 32'h7, 4'hF, 1'b0, "stall ctrl7");
        for (int i = 0; i < 4; i++) begin
            rd(A_CURR, 32'h0, 1'b0, $sformatf("stall%0d", i));
        end
        rd(A_CTRL, 32'h7, 1'b0, "stall ctrl");

        // reset mid-operation, with a read pending
        wr(A_CNTR, 32'h10, 4'hF, 1'b0, "rm cntr");
        wr(A_CTRL, 32'h7, 4'hF, 1'b0, "rm ctrl");
        rd(A_CURR, 32'h10, 1'b0, "rm 16");
        rd(A_CURR, 32'hF, 1'b0, "rm 15");
        @(negedge clk);
        bus.i_MCmd  = 3'd2;
        bus.i_MAddr = A_CTRL;
        #2;
        nrst = 1'b0;
        #1;
        chk("rm async intr", {31'd0, intr}, 32'd0);
        chk("rm async resp", {30'd0, bus.o_SResp}, 32'd0);
        @(posedge clk);
        #1;
        bus.i_MCmd = 3'd0;
        chk("rm pend resp", {30'd0, bus.o_SResp}, 32'd0);
        chk("rm pend data", bus.o_SData, 32'd0);
        @(posedge clk);
        #1;
        nrst = 1'b1;
        rd(A_CTRL, 32'h0, 1'b0, "post rst ctrl");
        rd(A_CNTR, 32'h0, 1'b0, "post rst cntr");
        rd(A_CURR, 32'h0, 1'b0, "post rst curr");
        rd(A_CURR, 32'h0, 1'b0, "post rst curr2");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
